// File: rtl/hs_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hs_serializer
// Brief    : D-PHY HS lane serializer. Sends the sync byte and then payload
//            bytes LSB-first, two bits per clock, and drives the DDR enable.
//            Optional macro HS_TRAIL_EN adds an HS-trail of the inverted
//            final bit.
// Revision : 1.0 - initial release
// ============================================================================
module hs_serializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
`ifdef HS_TRAIL_EN
    ,
    parameter int TRAIL_CYCLES = 4
`endif
) (
    input  logic       TX_DDR_clk,
    input  logic       TX_rst,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       Serial_B1,
    output logic       Serial_B2,
    output logic       Enable,
    output logic       Busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SYNC  = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
`ifdef HS_TRAIL_EN
    localparam logic [1:0] c_TRAIL = 2'd3;
    localparam logic [1:0] c_BURST_END = c_TRAIL;
`else
    localparam logic [1:0] c_BURST_END = c_IDLE;
`endif

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_sh;
    logic [1:0] r_pc;
`ifdef HS_TRAIL_EN
    logic [3:0] r_tc;
    logic       r_last_bit;
`endif
    logic       w_busy;
    logic       w_ready;

    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (TxRequestHS) begin
                    w_next_state = c_SYNC;
                end
            end
            c_SYNC, c_DATA: begin
                if (r_pc == 2'd3) begin
                    w_next_state = TxRequestHS ? c_DATA : c_BURST_END;
                end
            end
`ifdef HS_TRAIL_EN
            c_TRAIL: begin
                if (r_tc == 4'd0) begin
                    w_next_state = c_IDLE;
                end
            end
`endif
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state != c_IDLE);
        w_ready = ((r_state == c_SYNC) || (r_state == c_DATA)) && (r_pc == 2'd3);
    end

    // The line bits come straight from sh[1:0]; trail and idle levels are
    // loaded into sh so both outputs stay flop-driven in every state.
    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            r_sh <= 8'd0;
            r_pc <= 2'd0;
`ifdef HS_TRAIL_EN
            r_tc       <= 4'd0;
            r_last_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (TxRequestHS) begin
                        r_sh <= SYNC_BYTE;
                        r_pc <= 2'd0;
`ifdef HS_TRAIL_EN
                        r_last_bit <= SYNC_BYTE[7];
`endif
                    end
                end
                c_SYNC, c_DATA: begin
                    if (r_pc != 2'd3) begin
                        r_sh <= {2'b00, r_sh[7:2]};
                        r_pc <= r_pc + 2'd1;
                    end else if (TxRequestHS) begin
                        r_sh <= TxDataHS;
                        r_pc <= 2'd0;
`ifdef HS_TRAIL_EN
                        r_last_bit <= TxDataHS[7];
`endif
                    end else begin
                        r_pc <= 2'd0;
`ifdef HS_TRAIL_EN
                        r_sh <= {8{~r_last_bit}};
                        r_tc <= 4'(TRAIL_CYCLES - 1);
`else
                        r_sh <= 8'd0;
`endif
                    end
                end
`ifdef HS_TRAIL_EN
                c_TRAIL: begin
                    if (r_tc == 4'd0) begin
                        r_sh <= 8'd0;
                    end else begin
                        r_tc <= r_tc - 4'd1;
                    end
                end
`endif
                default: begin
                    r_sh <= 8'd0;
                    r_pc <= 2'd0;
                end
            endcase
        end
    end

    assign TxReadyHS = w_ready;
    assign Enable    = w_busy;
    assign Busy      = w_busy;
    assign Serial_B1 = r_sh[0];
    assign Serial_B2 = r_sh[1];

endmodule
`default_nettype wire

// File: tb/tb_hs_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_serializer
// Brief    : Self-checking bench for hs_serializer using a burst-level model
//            of the expected line pairs, enable and handshake per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_serializer;

`ifdef HS_TRAIL_EN
    localparam int c_TRAIL = 4;
`else
    localparam int c_TRAIL = 0;
`endif
    localparam logic [7:0] c_SYNC = 8'hB8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] data;
    logic       b1, b2, en, busy, ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hs_serializer dut (
        .TX_DDR_clk  (clk),
        .TX_rst      (rst),
        .TxRequestHS (req),
        .TxDataHS    (data),
        .TxReadyHS   (ready),
        .Serial_B1   (b1),
        .Serial_B2   (b2),
        .Enable      (en),
        .Busy        (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_b1, input logic e_b2,
                             input logic e_en, input logic e_rdy);
        check({tag, " B1"},    int'(b1),    int'(e_b1));
        check({tag, " B2"},    int'(b2),    int'(e_b2));
        check({tag, " Enable"}, int'(en),   int'(e_en));
        check({tag, " Busy"},  int'(busy),  int'(e_en));
        check({tag, " Ready"}, int'(ready), int'(e_rdy));
    endtask

    // Entered at a negedge in an IDLE cycle. Request is dropped in cycle
    // 4*n+k (k = 0..3, i.e. somewhere inside the last payload byte).
    task automatic run_burst(input logic [7:0] pl[$], input int k, input bit early,
                             input int rst_at);
        int         n;
        int         act;
        int         len;
        int         xfers;
        int         g;
        int         p;
        logic [7:0] cur;
        logic [7:0] last;
        logic       e_b1, e_b2, e_en, e_rdy;
        n     = pl.size();
        act   = 4 * (n + 1);
        len   = act + c_TRAIL;
        xfers = 0;
        last  = (n == 0) ? c_SYNC : pl[n-1];
        req   = 1'b1;
        data  = 8'($urandom);
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c < act) begin
                g     = c / 4;
                p     = c % 4;
                cur   = (g == 0) ? c_SYNC : pl[g-1];
                e_b1  = cur[2*p];
                e_b2  = cur[2*p+1];
                e_en  = 1'b1;
                e_rdy = (p == 3);
            end else if (c < len) begin
                e_b1  = ~last[7];
                e_b2  = ~last[7];
                e_en  = 1'b1;
                e_rdy = 1'b0;
            end else begin
                e_b1  = 1'b0;
                e_b2  = 1'b0;
                e_en  = 1'b0;
                e_rdy = 1'b0;
            end
            check_all($sformatf("n%0d c%0d", n, c), e_b1, e_b2, e_en, e_rdy);
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_all("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                req = 1'b0;
                return;
            end
            data = 8'($urandom);
            if (c < act && (c % 4) == 3 && (c / 4) < n) data = pl[c/4];
            if (c == 4 * n + k) req = 1'b0;
            if (early && c_TRAIL > 0 && c == len - 1) req = 1'b1;
            if (req && ready) xfers++;
        end
        check($sformatf("transfers n%0d", n), xfers, n);
    endtask

    initial begin
        logic [7:0] q[$];
        int         n;
        rst  = 1'b1;
        req  = 1'b1;
        data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all($sformatf("reset %0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;

        q = '{8'hA5};
        run_burst(q, 3, 1'b0, -1);
        q = '{8'h00, 8'hFF, 8'h3C};
        run_burst(q, 0, 1'b1, -1);
        q = '{8'($urandom), 8'($urandom)};
        run_burst(q, 1, 1'b0, -1);
        q = '{8'h5A, 8'hC3};
        run_burst(q, 0, 1'b0, 9);
        q = '{8'h01};
        run_burst(q, 2, 1'b0, -1);

        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 4);
            q.delete();
            for (int j = 0; j < n; j++) q.push_back(8'($urandom));
            run_burst(q, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs_serializer.md
# hs_serializer

High-speed lane serializer for the MIPI D-PHY transmit path, sitting directly upstream of the DEFF DDR output flip-flop. It accepts bytes over a PPI-style request/ready handshake, prepends the HS sync byte, and emits each byte LSB-first as two bits per TX_DDR_clk cycle on Serial_B1/Serial_B2. It also drives DEFF's Enable, so a burst on Dp/Dn is framed exactly by this block.

## Interface
- SYNC_BYTE, 8'hB8: HS leader/sync byte sent before the first payload byte of every burst.
- TRAIL_CYCLES, 4: HS-trail length in TX_DDR_clk cycles, legal range 1..15. Used only with HS_TRAIL_EN.
- TX_DDR_clk  in  1  single clock, shared with DEFF; all state updates on its rising edge.
- TX_rst  in  1  reset, synchronous, active-high.
- TxRequestHS  in  1  burst request; held high for the whole burst.
- TxDataHS  in  8  payload byte; sampled on a rising edge where TxRequestHS && TxReadyHS.
- TxReadyHS  out  1  byte-accept strobe, decoded from registered state.
- Serial_B1  out  1  even bit (2k) of the current pair, to DEFF rising-edge input.
- Serial_B2  out  1  odd bit (2k+1) of the current pair, to DEFF falling-edge input.
- Enable  out  1  DEFF output enable.
- Busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SYNC, DATA, TRAIL. TRAIL exists only with HS_TRAIL_EN.
- Registers:
  - 8-bit shift register sh.
  - 2-bit pair counter pc.
  - 4-bit trail counter tc.
  - 1-bit last_bit, holding bit 7 of the byte currently in sh.
- Serial_B1 = sh[0] and Serial_B2 = sh[1], both registered. Each cycle in SYNC/DATA, sh shifts right by 2 and pc increments (wraps 3→0).
- Handshake: TxReadyHS = (state==SYNC || state==DATA) && pc==3.
- At a rising edge with pc==3:
  - If TxRequestHS: load sh ← TxDataHS, pc ← 0, go to DATA.
  - Else: go to TRAIL when HS_TRAIL_EN is defined, otherwise IDLE.
- IDLE → SYNC when TxRequestHS is high at the edge. On that edge: sh ← SYNC_BYTE, pc ← 0, Enable ← 1.
- Request deasserted mid-byte (pc≠3) is ignored; the current byte always completes.
- Request low at pc==3 while still in SYNC ends the burst with zero payload bytes; last_bit is SYNC_BYTE[7].
- TRAIL:
  - Serial_B1 = Serial_B2 = ~last_bit and Enable = 1 for TRAIL_CYCLES cycles (tc counts down).
  - Then IDLE. TxRequestHS is ignored until IDLE is reached.
- IDLE: Enable = 0, Serial_B1 = Serial_B2 = 0, TxReadyHS = 0.
- Reset values: state IDLE, sh 0, pc 0, tc 0, all outputs 0.
- Reset wins over every other event, including mid-burst, on the same edge.

## Timing
- Request-to-line latency: TxRequestHS sampled high at edge N → first SYNC pair on Serial_B1/B2 and Enable=1 after edge N.
- SYNC_BYTE occupies 4 cycles. With 8'hB8, (B1,B2) pairs are (0,0),(0,1),(1,1),(0,1).
- First TxReadyHS occurs in the 4th SYNC cycle. Bytes are then accepted every 4th cycle, giving gapless throughput of one byte per 4 cycles.
- A byte accepted at edge M appears as pairs (d0,d1),(d2,d3),(d4,d5),(d6,d7) in the 4 cycles after M.
- Burst end without HS_TRAIL_EN: Enable falls on the edge after the final pair cycle.
- Burst end with HS_TRAIL_EN: Enable falls TRAIL_CYCLES cycles later than without it.
- Earliest new burst: request seen in IDLE. Minimum one IDLE cycle (Enable=0) between bursts.

## Configuration
- HS_TRAIL_EN defined:
  - TRAIL state and tc are compiled in.
  - Each burst ends with TRAIL_CYCLES cycles of the inverted final bit.
- HS_TRAIL_EN undefined:
  - No TRAIL state.
  - DATA/SYNC go straight to IDLE at end of burst.
  - tc is not instantiated.

## Test plan
- Reset: hold TX_rst high 3 cycles while TxRequestHS=1 → all outputs 0, Busy=0. Release → SYNC begins one cycle later.
- Single byte 8'hA5, TRAIL_CYCLES=4, HS_TRAIL_EN defined:
  - pairs (0,0),(0,1),(1,1),(0,1), then (1,0),(1,0),(0,1),(0,1).
  - then 4 cycles of (0,0) (trail of ~1).
  - Enable high 12 cycles total; exactly one TxReadyHS·TxRequestHS transfer.
- Back-to-back 8'h00, 8'hFF, 8'h3C with request held: no idle gaps between bytes. TxReadyHS pulses every 4 cycles. Last pairs are (0,0),(1,1),(1,1),(0,0).
- Request dropped at pc=1 of second byte: byte completes all 4 pairs. No further transfer occurs. Trail value = ~bit7 of that byte.
- TX_rst asserted mid-DATA: next edge gives Enable=0, Serial_B1/B2=0, Busy=0. A new request then produces a full fresh SYNC_BYTE.
- Build without HS_TRAIL_EN, single byte 8'h01: Enable high exactly 8 cycles. Busy=0 on the edge after the last pair.
